// File: rtl/zpu_sim_mem_io_if.sv
// Memory port between zpu_core (master) and its bus responder (slave).
// Signal names follow the core's own memory port.
interface zpu_sim_mem_io_if #(
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [31:0]           mem_write;
  logic                  out_mem_writeEnable;
  logic                  out_mem_readEnable;
  logic [3:0]            mem_writeMask;
  logic [31:0]           mem_read;
  logic                  in_mem_busy;

  modport master (
    output out_mem_addr, mem_write, out_mem_writeEnable, out_mem_readEnable, mem_writeMask,
    input  mem_read, in_mem_busy
  );

  modport slave (
    input  out_mem_addr, mem_write, out_mem_writeEnable, out_mem_readEnable, mem_writeMask,
    output mem_read, in_mem_busy
  );
endinterface

// File: rtl/zpu_sim_mem_io.sv
// Simulation/bring-up memory responder for zpu_core: byte-maskable word RAM,
// programmable wait states and an IO window with UART TX FIFO, cycle and overflow counters.
module zpu_sim_mem_io #(
  parameter int ADDR_WIDTH    = 28,
  parameter int RAM_AW        = 14,
  parameter int WAIT_STATES   = 1,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  zpu_sim_mem_io_if.slave   bus,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              proto_err
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int PW       = TX_DEPTH_LOG2 + 1;
  localparam int RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  is_wr_q, is_wr_d;
  logic [31:0]           mem_read_q, mem_read_d;
  logic                  proto_err_q, proto_err_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_full_q, tx_full_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [31:0]           ovf_q, ovf_d;

  logic [31:0] ram_mem [0:RAM_WORDS-1];
  logic [7:0]  fifo_mem [0:TX_DEPTH-1];

  logic                  req;
  logic                  acc_go;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_data;
  logic [3:0]            acc_mask;
  logic                  acc_wr;
  logic                  acc_io;
  logic [1:0]            acc_off;
  logic [RAM_AW-1:0]     ram_idx;
  logic                  ram_we;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic [31:0]           io_rdata;
  logic                  unused_addr_bits;

  assign req = bus.out_mem_writeEnable | bus.out_mem_readEnable;

  // Access sequencing; with zero wait states the live request is serviced straight from IDLE.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    is_wr_d  = is_wr_q;
    acc_go   = 1'b0;
    acc_addr = addr_q;
    acc_data = wdata_q;
    acc_mask = mask_q;
    acc_wr   = is_wr_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            acc_go   = 1'b1;
            acc_addr = bus.out_mem_addr;
            acc_data = bus.mem_write;
            acc_mask = bus.mem_writeMask;
            acc_wr   = bus.out_mem_writeEnable;
          end else begin
            addr_d  = bus.out_mem_addr;
            wdata_d = bus.mem_write;
            mask_d  = bus.mem_writeMask;
            is_wr_d = bus.out_mem_writeEnable;
            wcnt_d  = 4'(WAIT_STATES - 1);
            busy_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          acc_go  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign acc_io   = acc_addr[ADDR_WIDTH-1];
  assign acc_off  = acc_addr[3:2];
  assign ram_idx  = acc_addr[RAM_AW+1:2];
  assign ram_we   = acc_go & acc_wr & ~acc_io & ~reset;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[ADDR_WIDTH-2:RAM_AW+2]};

  // FIFO and IO-register bookkeeping; a push into a full FIFO still lands if the sink pops on the same edge.
  always_comb begin
    pop      = tx_valid_q & tx_ready;
    push_req = acc_go & acc_wr & acc_io & (acc_off == 2'd0);
    push     = push_req & (~tx_full_q | pop);

    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};

    tx_valid_d = (wr_ptr_d != rd_ptr_d);
    tx_full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                 (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);

    if (push && (wr_ptr_q[PW-2:0] == rd_ptr_d[PW-2:0])) begin
      tx_data_d = acc_data[7:0];
    end else begin
      tx_data_d = fifo_mem[rd_ptr_d[PW-2:0]];
    end

    ovf_d = ovf_q;
    if (acc_go && acc_wr && acc_io && (acc_off == 2'd2)) begin
      ovf_d = 32'd0;
    end else if (push_req && !push && (ovf_q != 32'hFFFF_FFFF)) begin
      ovf_d = ovf_q + 32'd1;
    end

    cycle_d = cycle_q + 32'd1;
  end

  // Read data path; writes (including read+write collisions) leave mem_read untouched.
  always_comb begin
    case (acc_off)
      2'd0:    io_rdata = {23'd0, ~tx_full_q, 8'h00};
      2'd1:    io_rdata = cycle_q;
      2'd2:    io_rdata = ovf_q;
      default: io_rdata = 32'd0;
    endcase

    mem_read_d = mem_read_q;
    if (acc_go && !acc_wr) begin
      mem_read_d = acc_io ? io_rdata : ram_mem[ram_idx];
    end

    proto_err_d = proto_err_q;
    if ((req && (state_q != S_IDLE)) || (bus.out_mem_writeEnable && bus.out_mem_readEnable)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      mask_q      <= 4'd0;
      is_wr_q     <= 1'b0;
      mem_read_q  <= 32'd0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_full_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      cycle_q     <= 32'd0;
      ovf_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      is_wr_q     <= is_wr_d;
      mem_read_q  <= mem_read_d;
      proto_err_q <= proto_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tx_valid_q  <= tx_valid_d;
      tx_full_q   <= tx_full_d;
      tx_data_q   <= tx_data_d;
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage arrays are deliberately not reset; reset only blocks a commit on its edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) begin
          ram_mem[ram_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_q[PW-2:0]] <= acc_data[7:0];
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.in_mem_busy = busy_q;
  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_zpu_sim_mem_io.sv
// Directed + randomized bench for zpu_sim_mem_io: a one-wait-state instance and a zero-wait
// instance, checked against a word/FIFO/counter reference model kept here.
module tb_zpu_sim_mem_io;

  localparam int AW = 28;
  localparam logic [27:0] IO_UART  = 28'h800_0000;
  localparam logic [27:0] IO_CYCLE = 28'h800_0004;
  localparam logic [27:0] IO_OVF   = 28'h800_0008;
  localparam logic [27:0] IO_RSVD  = 28'h800_000C;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid, tx_ready, proto_err;
  logic [7:0] tx_data;
  logic       tx_valid0, tx_ready0, proto_err0;
  logic [7:0] tx_data0;

  int vectors = 0;
  int miscompares = 0;

  zpu_sim_mem_io_if #(.ADDR_WIDTH(AW)) bus ();
  zpu_sim_mem_io_if #(.ADDR_WIDTH(AW)) bus0 ();

  zpu_sim_mem_io #(.ADDR_WIDTH(AW), .RAM_AW(14), .WAIT_STATES(1), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .proto_err(proto_err)
  );

  zpu_sim_mem_io #(.ADDR_WIDTH(AW), .RAM_AW(14), .WAIT_STATES(0), .TX_DEPTH_LOG2(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0), .proto_err(proto_err0)
  );

  always #5 clk = ~clk;

  // Reference model state: word memory, FIFO contents, counters, sticky error, last read.
  logic [31:0]  ref_mem [int];
  logic [7:0]   ref_fifo [$];
  logic [31:0]  ref_ovf;
  logic         ref_proto;
  logic [31:0]  last_read;
  int unsigned  tb_cycles;

  always @(posedge clk) begin
    if (reset) tb_cycles <= 0;
    else       tb_cycles <= tb_cycles + 1;
  end

  function automatic int widx(logic [27:0] a);
    return int'((a >> 2) % (1 << 14));
  endfunction

  function automatic logic [31:0] model_read(logic [27:0] a, int unsigned cyc);
    if (a[27]) begin
      case (a[3:2])
        2'd0:    return {23'd0, (ref_fifo.size() < 16) ? 1'b1 : 1'b0, 8'h00};
        2'd1:    return cyc;
        2'd2:    return ref_ovf;
        default: return 32'd0;
      endcase
    end
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
  endfunction

  task automatic model_write(logic [27:0] a, logic [31:0] d, logic [3:0] m);
    logic [31:0] w;
    if (a[27]) begin
      if (a[3:2] == 2'd0) begin
        if (ref_fifo.size() < 16) ref_fifo.push_back(d[7:0]);
        else if (ref_ovf != 32'hFFFF_FFFF) ref_ovf = ref_ovf + 1;
      end else if (a[3:2] == 2'd2) begin
        ref_ovf = 32'd0;
      end
    end else begin
      w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[widx(a)] = w;
    end
  endtask

  task automatic model_reset();
    ref_fifo.delete();
    ref_ovf   = 32'd0;
    ref_proto = 1'b0;
    last_read = 32'd0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.out_mem_writeEnable = 1'b0;
    bus.out_mem_readEnable  = 1'b0;
    bus.out_mem_addr        = 28'($urandom);
    bus.mem_write           = $urandom;
    bus.mem_writeMask       = 4'($urandom);
  endtask

  task automatic idle_bus0();
    bus0.out_mem_writeEnable = 1'b0;
    bus0.out_mem_readEnable  = 1'b0;
    bus0.out_mem_addr        = 28'($urandom);
    bus0.mem_write           = $urandom;
    bus0.mem_writeMask       = 4'($urandom);
  endtask

  task automatic drive_req(input logic [27:0] a, input logic [31:0] d,
                           input logic we, input logic re, input logic [3:0] m);
    bus.out_mem_addr        = a;
    bus.mem_write           = d;
    bus.out_mem_writeEnable = we;
    bus.out_mem_readEnable  = re;
    bus.mem_writeMask       = m;
  endtask

  // One complete access on the one-wait-state instance, checked every cycle.
  task automatic apply_stimulus(input logic [27:0] a, input logic [31:0] d, input logic we,
                                input logic re, input logic [3:0] m, input string tag,
                                output logic [31:0] got);
    int unsigned cyc;
    @(negedge clk);
    drive_req(a, d, we, re, m);
    @(negedge clk);
    idle_bus();
    cyc = tb_cycles;
    check_output({tag, " busy_wait"}, {31'd0, bus.in_mem_busy}, 32'd1);
    @(negedge clk);
    check_output({tag, " busy_done"}, {31'd0, bus.in_mem_busy}, 32'd0);
    if (we && re) ref_proto = 1'b1;
    if (we) model_write(a, d, m);
    else if (re) last_read = model_read(a, cyc);
    got = bus.mem_read;
    check_output({tag, " mem_read"}, got, last_read);
    check_output({tag, " proto_err"}, {31'd0, proto_err}, {31'd0, ref_proto});
    check_output({tag, " tx_valid"}, {31'd0, tx_valid}, {31'd0, ref_fifo.size() > 0});
    if (ref_fifo.size() > 0) check_output({tag, " tx_data"}, {24'd0, tx_data}, {24'd0, ref_fifo[0]});
  endtask

  task automatic drain_fifo(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      check_output({tag, " drain_valid"}, {31'd0, tx_valid}, 32'd1);
      check_output({tag, " drain_data"}, {24'd0, tx_data}, {24'd0, ref_fifo.pop_front()});
    end
    @(negedge clk);
    tx_ready = 1'b0;
    check_output({tag, " drained_empty"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] got, c1, old80;
    logic [27:0] ra [8];
    logic [27:0] a0 [6];
    logic [31:0] d0 [6];
    logic [7:0]  b;

    reset = 1'b1;
    tx_ready = 1'b0;
    tx_ready0 = 1'b0;
    idle_bus();
    idle_bus0();
    model_reset();
    repeat (3) @(negedge clk);
    check_output("rst mem_read", bus.mem_read, 32'd0);
    check_output("rst busy", {31'd0, bus.in_mem_busy}, 32'd0);
    check_output("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check_output("rst tx_data", {24'd0, tx_data}, 32'd0);
    check_output("rst proto_err", {31'd0, proto_err}, 32'd0);
    reset = 1'b0;

    // Full-word write then read, then a single-byte masked write.
    apply_stimulus(28'h40, 32'h1234_5678, 1'b1, 1'b0, 4'b1111, "t1 wr", got);
    apply_stimulus(28'h40, 32'h0, 1'b0, 1'b1, 4'b0000, "t1 rd", got);
    check_output("t1 const", got, 32'h1234_5678);
    apply_stimulus(28'h40, 32'hAABB_CCDD, 1'b1, 1'b0, 4'b0100, "t2 wr", got);
    apply_stimulus(28'h40, 32'h0, 1'b0, 1'b1, 4'b0000, "t2 rd", got);
    check_output("t2 const", got, 32'h12BB_5678);

    // Randomized RAM traffic over a few words, with random alias bits above the RAM index.
    for (int i = 0; i < 8; i++) begin
      ra[i] = (28'($urandom) & 28'h7FF_0000) | 28'(16'h1000 + 16'(i * 4));
      apply_stimulus(ra[i], $urandom, 1'b1, 1'b0, 4'b1111, "rnd init", got);
    end
    for (int i = 0; i < 24; i++) begin
      int j;
      logic [27:0] alias_a;
      j = $urandom_range(0, 7);
      alias_a = (ra[j] & 28'h000_FFFF) | (28'($urandom) & 28'h7FF_0000);
      if ($urandom_range(0, 1) == 0)
        apply_stimulus(alias_a, $urandom, 1'b1, 1'b0, 4'($urandom), "rnd wr", got);
      else
        apply_stimulus(alias_a, $urandom, 1'b0, 1'b1, 4'($urandom), "rnd rd", got);
    end

    // Zero-wait instance: back-to-back writes then back-to-back reads.
    for (int i = 0; i < 6; i++) begin
      a0[i] = 28'(28'h200 + i * 4) | (28'($urandom_range(0, 255)) << 16);
      d0[i] = $urandom;
    end
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) check_output("t3 wr busy", {31'd0, bus0.in_mem_busy}, 32'd0);
      if (k < 6) begin
        bus0.out_mem_addr = a0[k];
        bus0.mem_write = d0[k];
        bus0.mem_writeMask = 4'b1111;
        bus0.out_mem_writeEnable = 1'b1;
        bus0.out_mem_readEnable = 1'b0;
      end else idle_bus0();
    end
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check_output("t3 rd busy", {31'd0, bus0.in_mem_busy}, 32'd0);
        check_output("t3 rd data", bus0.mem_read, d0[k-1]);
      end
      if (k < 6) begin
        bus0.out_mem_addr = a0[k];
        bus0.mem_write = $urandom;
        bus0.out_mem_writeEnable = 1'b0;
        bus0.out_mem_readEnable = 1'b1;
      end else idle_bus0();
    end
    check_output("t3 proto_err", {31'd0, proto_err0}, 32'd0);

    // Cycle counter, its write-ignore, and the reserved slot.
    apply_stimulus(IO_CYCLE, 32'h0, 1'b0, 1'b1, 4'd0, "cyc rd1", c1);
    apply_stimulus(IO_CYCLE, 32'h0, 1'b0, 1'b1, 4'd0, "cyc rd2", got);
    check_output("cyc delta", got - c1, 32'd3);
    apply_stimulus(IO_CYCLE, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF, "cyc wr", got);
    apply_stimulus(IO_CYCLE, 32'h0, 1'b0, 1'b1, 4'd0, "cyc rd3", got);
    apply_stimulus(IO_RSVD, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, "rsvd wr", got);
    apply_stimulus(IO_RSVD, 32'h0, 1'b0, 1'b1, 4'd0, "rsvd rd", got);
    check_output("rsvd const", got, 32'd0);

    // Overfill the FIFO by one, then drain it.
    for (int i = 0; i < 17; i++)
      apply_stimulus(IO_UART, $urandom, 1'b1, 1'b0, 4'($urandom), "t4 push", got);
    apply_stimulus(IO_UART, 32'h0, 1'b0, 1'b1, 4'd0, "t4 uart", got);
    check_output("t4 uart const", got, 32'h0000_0000);
    apply_stimulus(IO_OVF, 32'h0, 1'b0, 1'b1, 4'd0, "t4 ovf", got);
    check_output("t4 ovf const", got, 32'd1);
    drain_fifo(16, "t4");
    apply_stimulus(IO_UART, 32'h0, 1'b0, 1'b1, 4'd0, "t4 uart2", got);
    check_output("t4 uart2 const", got, 32'h0000_0100);

    // Push into a full FIFO on the same edge the sink pops.
    apply_stimulus(IO_OVF, $urandom, 1'b1, 1'b0, 4'd0, "t5 ovf clr", got);
    apply_stimulus(IO_OVF, 32'h0, 1'b0, 1'b1, 4'd0, "t5 ovf rd", got);
    for (int i = 0; i < 16; i++)
      apply_stimulus(IO_UART, $urandom, 1'b1, 1'b0, 4'hF, "t5 fill", got);
    b = 8'($urandom);
    @(negedge clk);
    drive_req(IO_UART, {24'($urandom), b}, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    idle_bus();
    tx_ready = 1'b1;
    check_output("t5 busy", {31'd0, bus.in_mem_busy}, 32'd1);
    check_output("t5 head", {24'd0, tx_data}, {24'd0, ref_fifo[0]});
    @(negedge clk);
    tx_ready = 1'b0;
    void'(ref_fifo.pop_front());
    ref_fifo.push_back(b);
    check_output("t5 busy_done", {31'd0, bus.in_mem_busy}, 32'd0);
    apply_stimulus(IO_OVF, 32'h0, 1'b0, 1'b1, 4'd0, "t5 ovf", got);
    check_output("t5 ovf const", got, 32'd0);
    apply_stimulus(IO_UART, 32'h0, 1'b0, 1'b1, 4'd0, "t5 uart", got);
    check_output("t5 uart const", got, 32'h0000_0000);
    drain_fifo(16, "t5");

    // Reset during the wait state of a write: the write is lost, state is cleared.
    old80 = $urandom;
    apply_stimulus(28'h80, old80, 1'b1, 1'b0, 4'hF, "t6 pre", got);
    apply_stimulus(IO_UART, 32'h55, 1'b1, 1'b0, 4'hF, "t6 push", got);
    @(negedge clk);
    drive_req(28'h80, ~old80, 1'b1, 1'b0, 4'hF);
    @(negedge clk);
    idle_bus();
    check_output("t6 busy", {31'd0, bus.in_mem_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_output("t6 busy_after", {31'd0, bus.in_mem_busy}, 32'd0);
    check_output("t6 tx_valid", {31'd0, tx_valid}, 32'd0);
    check_output("t6 mem_read", bus.mem_read, 32'd0);
    apply_stimulus(28'h80, 32'h0, 1'b0, 1'b1, 4'd0, "t6 rd", got);
    check_output("t6 old", got, old80);
    apply_stimulus(IO_UART, 32'h0, 1'b0, 1'b1, 4'd0, "t6 uart", got);

    // Read and write together: write lands, read dropped, sticky error.
    apply_stimulus(28'h100, 32'hCAFE_F00D, 1'b1, 1'b1, 4'hF, "t7 rw", got);
    check_output("t7 proto const", {31'd0, proto_err}, 32'd1);
    apply_stimulus(28'h100, 32'h0, 1'b0, 1'b1, 4'd0, "t7 rd", got);
    check_output("t7 data const", got, 32'hCAFE_F00D);

    // A request issued while busy is ignored and flags an error.
    pulse_reset();
    apply_stimulus(28'h140, 32'h1111_1111, 1'b1, 1'b0, 4'hF, "t8 preB", got);
    @(negedge clk);
    drive_req(28'h180, 32'h2222_2222, 1'b1, 1'b0, 4'hF);
    @(negedge clk);
    drive_req(28'h140, 32'h3333_3333, 1'b1, 1'b0, 4'hF);
    check_output("t8 busy", {31'd0, bus.in_mem_busy}, 32'd1);
    @(negedge clk);
    idle_bus();
    model_write(28'h180, 32'h2222_2222, 4'hF);
    ref_proto = 1'b1;
    check_output("t8 proto", {31'd0, proto_err}, 32'd1);
    apply_stimulus(28'h140, 32'h0, 1'b0, 1'b1, 4'd0, "t8 rdB", got);
    apply_stimulus(28'h180, 32'h0, 1'b0, 1'b1, 4'd0, "t8 rdA", got);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
